mips_processor: RTL and testbench



---
 rtl/mips_processor.sv | 144 ++++++++++++++
 tb/tb_mips_processor.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_processor.sv
// mips_processor: single-cycle MIPS-I subset core (ADD/SUB/AND/OR/SLT/LW/SW/BEQ) with private memories.
// Latency: one instruction retires per clk edge; no backpressure, no stalls, no handshakes.

module mips_imem (
  input  logic        clk,
  input  logic        load,
  input  logic [7:0]  load_addr,
  input  logic [31:0] load_data,
  input  logic [7:0]  addr,
  output logic [31:0] data
);
  logic [31:0] memory [256];

  // Program normally arrives by preload; the load port is idle inside this core.
  always_ff @(posedge clk) begin
    if (load) memory[load_addr] <= load_data;
  end

  assign data = memory[addr];
endmodule

module mips_regfile (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] registers [32];

  always_ff @(posedge clk) begin
    if (we && wa != 5'd0) registers[wa] <= wd;
  end

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : registers[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : registers[ra2];
endmodule

module mips_dmem (
  input  logic        clk,
  input  logic        we,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  logic [31:0] memory [256];

  always_ff @(posedge clk) begin
    if (we) memory[addr] <= wdata;
  end

  assign rdata = memory[addr];
endmodule

module mips_processor (
  input logic clk,
  input logic reset
);
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

  logic [31:0] pc, pc_plus4, pc_next, instr, imm_ext;
  logic [31:0] rs_val, rt_val, alu_b, alu_y, mem_rdata, wb_data;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, wreg;
  logic        reg_we, mem_we, use_imm, mem_to_reg, branch, zero;
  alu_op_t     alu_op;

  mips_imem imem (
    .clk(clk), .load(1'b0), .load_addr(8'd0), .load_data(32'd0),
    .addr(pc[9:2]), .data(instr)
  );

  assign op      = instr[31:26];
  assign rs      = instr[25:21];
  assign rt      = instr[20:16];
  assign rd      = instr[15:11];
  assign funct   = instr[5:0];
  assign imm_ext = {{16{instr[15]}}, instr[15:0]};

  always_comb begin
    reg_we     = 1'b0;
    mem_we     = 1'b0;
    use_imm    = 1'b0;
    mem_to_reg = 1'b0;
    branch     = 1'b0;
    wreg       = rd;
    alu_op     = ALU_ADD;
    case (op)
      6'b000000: begin
        case (funct)
          6'b100000: begin reg_we = 1'b1; alu_op = ALU_ADD; end
          6'b100010: begin reg_we = 1'b1; alu_op = ALU_SUB; end
          6'b100100: begin reg_we = 1'b1; alu_op = ALU_AND; end
          6'b100101: begin reg_we = 1'b1; alu_op = ALU_OR;  end
          6'b101010: begin reg_we = 1'b1; alu_op = ALU_SLT; end
          default: ;
        endcase
      end
      6'b100011: begin reg_we = 1'b1; wreg = rt; use_imm = 1'b1; mem_to_reg = 1'b1; end
      6'b101011: begin mem_we = 1'b1; use_imm = 1'b1; end
      6'b000100: begin branch = 1'b1; alu_op = ALU_SUB; end
      default: ;
    endcase
  end

  mips_regfile rf (
    .clk(clk), .we(reg_we & reset), .ra1(rs), .ra2(rt),
    .wa(wreg), .wd(wb_data), .rd1(rs_val), .rd2(rt_val)
  );

  assign alu_b = use_imm ? imm_ext : rt_val;

  always_comb begin
    alu_y = 32'd0;
    case (alu_op)
      ALU_ADD: alu_y = rs_val + alu_b;
      ALU_SUB: alu_y = rs_val - alu_b;
      ALU_AND: alu_y = rs_val & alu_b;
      ALU_OR:  alu_y = rs_val | alu_b;
      ALU_SLT: alu_y = ($signed(rs_val) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_y = 32'd0;
    endcase
  end

  assign zero = (alu_y == 32'd0);

  // Writes are gated by reset so an edge during reset commits nothing.
  mips_dmem dmem (
    .clk(clk), .we(mem_we & reset), .addr(alu_y[9:2]),
    .wdata(rt_val), .rdata(mem_rdata)
  );

  assign wb_data  = mem_to_reg ? mem_rdata : alu_y;
  assign pc_plus4 = pc + 32'd4;
  assign pc_next  = (branch && zero) ? pc_plus4 + {imm_ext[29:0], 2'b00} : pc_plus4;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc <= 32'd0;
    else        pc <= pc_next;
  end
endmodule

// File: tb/tb_mips_processor.sv
// Bench for mips_processor: directed program table, reset corner cases, random programs vs. an ISA model.
module tb_mips_processor;
  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  mips_processor dut (.clk(clk), .reset(reset));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic        pre_clear;
    int          kind;      // 0: register, 1: data memory word
    int          idx;
    logic [31:0] exp_val;
    logic [31:0] exp_pc;
  } vec_t;

  logic [31:0] m_imem [256];
  logic [31:0] m_mem  [256];
  logic [31:0] m_reg  [32];
  logic [31:0] m_pc;
  logic [31:0] prog   [14];
  vec_t        vecs   [15];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] f);
    logic [4:0] a, b, c;
    a = rs[4:0]; b = rt[4:0]; c = rd[4:0];
    return {6'b000000, a, b, c, 5'b00000, f};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    logic [4:0] a, b;
    a = rs[4:0]; b = rt[4:0];
    return {op, a, b, imm};
  endfunction

  // ISA-level reference: executes one instruction on the model arrays.
  task automatic model_step();
    logic [31:0] ins, a, b, sx, addr, nxt, res;
    int rs, rt, rd;
    logic wr;
    ins = m_imem[m_pc[9:2]];
    rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]);
    a  = (rs == 0) ? 32'd0 : m_reg[rs];
    b  = (rt == 0) ? 32'd0 : m_reg[rt];
    sx = {{16{ins[15]}}, ins[15:0]};
    nxt = m_pc + 32'd4;
    wr = 1'b0; res = 32'd0;
    case (ins[31:26])
      6'h00: begin
        wr = 1'b1;
        case (ins[5:0])
          6'h20: res = a + b;
          6'h22: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: wr = 1'b0;
        endcase
        if (wr && rd != 0) m_reg[rd] = res;
      end
      6'h23: begin addr = a + sx; if (rt != 0) m_reg[rt] = m_mem[addr[9:2]]; end
      6'h2B: begin addr = a + sx; m_mem[addr[9:2]] = b; end
      6'h04: if (a == b) nxt = m_pc + 32'd4 + sx * 4;
      default: ;
    endcase
    m_pc = nxt;
  endtask

  task automatic load_dut();
    for (int i = 0; i < 256; i++) begin
      dut.imem.memory[i] = m_imem[i];
      dut.dmem.memory[i] = m_mem[i];
    end
    for (int i = 0; i < 32; i++) dut.rf.registers[i] = m_reg[i];
  endtask

  task automatic directed_setup();
    reset = 1'b0;
    for (int i = 0; i < 256; i++) begin m_imem[i] = 32'd0; m_mem[i] = 32'd0; end
    for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
    for (int i = 0; i < 14; i++) m_imem[i] = prog[i];
    m_reg[9] = 32'd1; m_reg[10] = 32'd2; m_reg[11] = 32'd3; m_reg[12] = 32'h55;
    m_mem[1] = 32'hDEADBEEF;
    load_dut();
  endtask

  initial begin
    logic [31:0] garbage, act;
    reset = 1'b0;
    garbage = 32'hFC00_0000;
    prog[0]  = enc_r(10, 11, 9, 6'h20);
    prog[1]  = enc_r(10, 11, 9, 6'h22);
    prog[2]  = enc_r(10, 11, 9, 6'h24);
    prog[3]  = enc_r(10, 11, 9, 6'h25);
    prog[4]  = enc_r(10, 11, 9, 6'h2A);
    prog[5]  = enc_i(6'h23, 10, 9, 16'd4);
    prog[6]  = enc_i(6'h2B, 10, 9, 16'd4);
    prog[7]  = enc_i(6'h04, 9, 10, 16'd2);
    prog[8]  = enc_r(10, 0, 9, 6'h20);
    prog[9]  = enc_i(6'h04, 0, 0, 16'hFFFD);
    prog[10] = enc_r(10, 11, 0, 6'h20);
    prog[11] = enc_r(0, 0, 12, 6'h20);
    prog[12] = garbage;
    prog[13] = enc_r(10, 11, 9, 6'h27);

    vecs[0]  = '{"add",        1'b0, 0, 9,  32'h5,        32'h04};
    vecs[1]  = '{"sub",        1'b0, 0, 9,  32'hFFFFFFFF, 32'h08};
    vecs[2]  = '{"and",        1'b0, 0, 9,  32'h2,        32'h0C};
    vecs[3]  = '{"or",         1'b0, 0, 9,  32'h3,        32'h10};
    vecs[4]  = '{"slt",        1'b0, 0, 9,  32'h1,        32'h14};
    vecs[5]  = '{"lw",         1'b0, 0, 9,  32'hDEADBEEF, 32'h18};
    vecs[6]  = '{"sw",         1'b1, 1, 1,  32'hDEADBEEF, 32'h1C};
    vecs[7]  = '{"beq_nt",     1'b0, 0, 9,  32'hDEADBEEF, 32'h20};
    vecs[8]  = '{"mov",        1'b0, 0, 9,  32'h2,        32'h24};
    vecs[9]  = '{"beq_back",   1'b0, 0, 9,  32'h2,        32'h1C};
    vecs[10] = '{"beq_taken",  1'b0, 0, 9,  32'h2,        32'h28};
    vecs[11] = '{"wr_r0",      1'b0, 0, 0,  32'h0,        32'h2C};
    vecs[12] = '{"rd_r0",      1'b0, 0, 12, 32'h0,        32'h30};
    vecs[13] = '{"bad_op",     1'b0, 0, 9,  32'h2,        32'h34};
    vecs[14] = '{"bad_funct",  1'b0, 0, 9,  32'h2,        32'h38};

    // Directed program
    directed_setup();
    @(negedge clk);
    check("reset_pc", dut.pc, 32'h0);
    reset = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].pre_clear) dut.dmem.memory[1] = 32'd0;
      @(posedge clk);
      @(negedge clk);
      check({vecs[i].name, "_pc"}, dut.pc, vecs[i].exp_pc);
      act = (vecs[i].kind == 0) ? dut.rf.registers[vecs[i].idx] : dut.dmem.memory[vecs[i].idx];
      check(vecs[i].name, act, vecs[i].exp_val);
    end
    check("sw_keeps_r9", dut.rf.registers[9], 32'hDEADBEEF ^ 32'hDEADBEEF ^ 32'h2);

    // Reset asserted mid-program
    directed_setup();
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("mid_pc_before", dut.pc, 32'h10);
    reset = 1'b0;
    #1;
    check("mid_pc_async", dut.pc, 32'h0);
    check("mid_r9_kept", dut.rf.registers[9], 32'h3);
    @(posedge clk);
    @(negedge clk);
    check("mid_pc_held", dut.pc, 32'h0);
    check("mid_no_commit", dut.rf.registers[9], 32'h3);
    check("mid_dmem_kept", dut.dmem.memory[1], 32'hDEADBEEF);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("restart_pc", dut.pc, 32'h4);
    check("restart_add", dut.rf.registers[9], 32'h5);

    // Random programs against the ISA model
    for (int run = 0; run < 3; run++) begin
      reset = 1'b0;
      for (int i = 0; i < 256; i++) begin
        int rs, rt, rd, k;
        logic [15:0] imm;
        logic [5:0] fsel;
        rs = $urandom_range(0, 31); rt = $urandom_range(0, 31); rd = $urandom_range(0, 31);
        imm = 16'($urandom);
        k = $urandom_range(0, 9);
        case (k)
          0: fsel = 6'h20;
          1: fsel = 6'h22;
          2: fsel = 6'h24;
          3: fsel = 6'h25;
          default: fsel = 6'h2A;
        endcase
        if (k <= 4)      m_imem[i] = enc_r(rs, rt, rd, fsel);
        else if (k == 5) m_imem[i] = enc_i(6'h23, rs, rt, imm);
        else if (k == 6) m_imem[i] = enc_i(6'h2B, rs, rt, imm);
        else if (k == 7) m_imem[i] = enc_i(6'h04, rs, ($urandom_range(0, 1) == 1) ? rs : rt,
                                           16'($urandom_range(0, 15)) - 16'd8);
        else if (k == 8) m_imem[i] = $urandom;
        else             m_imem[i] = enc_r(rs, rt, rd, 6'($urandom));
        m_mem[i] = $urandom;
      end
      for (int i = 0; i < 32; i++) m_reg[i] = (i == 0) ? 32'd0 : (($urandom_range(0, 3) == 0) ? 32'(i) : $urandom);
      m_pc = 32'd0;
      load_dut();
      @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 300; c++) begin
        model_step();
        @(posedge clk);
        @(negedge clk);
        check("rand_pc", dut.pc, m_pc);
      end
      for (int i = 1; i < 32; i++) check("rand_reg", dut.rf.registers[i], m_reg[i]);
      for (int i = 0; i < 256; i++) check("rand_mem", dut.dmem.memory[i], m_mem[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
